// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, HOLD, RUN} loader_state_t;

    localparam int WORD_BYTES = 4;

    typedef logic [31:0] word_t;

endpackage

// File: rtl/imem_hold_timer.sv
// Loadable down-counter that times the HOLD interval before the core is released.
module imem_hold_timer #(
    parameter int RESET_HOLD = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = $clog2(RESET_HOLD + 1);
    // Loaded on entry to HOLD; expires in the RESET_HOLD-th HOLD cycle.
    localparam logic [CNT_W-1:0] INIT = CNT_W'(RESET_HOLD - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= INIT;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/imem_loader.sv
// Streams program words into the MIPS instruction memory and sequences the core reset.
// Optional IMEM_LOADER_CHECKSUM_EN adds a running modulo-2^32 checksum output.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          MAX_WORDS  = 256,
    parameter int          RESET_HOLD = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        s_valid,
    input  logic [31:0] s_data,
    input  logic        s_last,
    output logic        s_ready,
    output logic [31:0] instrdatain,
    output logic [31:0] addwrite,
    output logic        instwen,
    output logic        cpu_reset,
    output logic        busy,
    output logic        done,
    output logic        overflow,
`ifdef IMEM_LOADER_CHECKSUM_EN
    output logic [31:0] checksum,
`endif
    output logic [15:0] word_count
);

    // One extra bit so MAX_WORDS = 2^16 is still representable.
    localparam int CNT_W = 17;

    loader_state_t    state, next_state;
    word_t            addr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_inc;
    logic             handshake;
    logic             full_hit;
    logic             start_load;
    logic             timer_load;
    logic             timer_expired;

    assign handshake  = s_valid && s_ready;
    assign count_inc  = count + 1'b1;
    assign full_hit   = (count_inc == CNT_W'(MAX_WORDS));
    assign start_load = start && ((state == IDLE) || (state == RUN));

    always_comb begin
        next_state = state;
        timer_load = 1'b0;
        case (state)
            IDLE: if (start) next_state = LOAD;
            LOAD: begin
                if (handshake && (s_last || full_hit)) begin
                    next_state = HOLD;
                    timer_load = 1'b1;
                end
            end
            HOLD: if (timer_expired) next_state = RUN;
            RUN:  if (start) next_state = LOAD;
            default: next_state = IDLE;
        endcase
    end

    imem_hold_timer #(.RESET_HOLD(RESET_HOLD)) u_hold_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (timer_load),
        .en      (state == HOLD),
        .expired (timer_expired)
    );

    // Control outputs are registered from next_state so they line up with the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            s_ready   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cpu_reset <= 1'b1;
        end else begin
            state     <= next_state;
            s_ready   <= (next_state == LOAD);
            busy      <= (next_state == LOAD) || (next_state == HOLD);
            done      <= (next_state == RUN);
            cpu_reset <= (next_state != RUN);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instwen     <= 1'b0;
            instrdatain <= '0;
            addwrite    <= BASE_ADDR;
            addr        <= BASE_ADDR;
            count       <= '0;
            overflow    <= 1'b0;
        end else begin
            instwen <= handshake;
            if (start_load) begin
                addr     <= BASE_ADDR;
                count    <= '0;
                overflow <= 1'b0;
            end else if (handshake) begin
                addwrite    <= addr;
                instrdatain <= s_data;
                addr        <= addr + 32'(WORD_BYTES);
                count       <= count_inc;
                if (full_hit && !s_last) overflow <= 1'b1;
            end
        end
    end

    assign word_count = count[15:0];

`ifdef IMEM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (reset || start_load) begin
            checksum <= '0;
        end else if (handshake) begin
            checksum <= checksum + s_data;
        end
    end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader (MAX_WORDS=4, RESET_HOLD=4).
module tb_imem_loader;
    import imem_loader_pkg::*;

    logic        clk = 1'b0;
    logic        reset, start, s_valid, s_last;
    logic [31:0] s_data;
    logic        s_ready, instwen, cpu_reset, busy, done, overflow;
    logic [31:0] instrdatain, addwrite;
    logic [15:0] word_count;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    word_t       src [8];
    logic [31:0] addr_q [$];
    logic [31:0] data_q [$];
    int          cyc_q  [$];

    imem_loader #(.BASE_ADDR(32'h0), .MAX_WORDS(4), .RESET_HOLD(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_last      (s_last),
        .s_ready     (s_ready),
        .instrdatain (instrdatain),
        .addwrite    (addwrite),
        .instwen     (instwen),
        .cpu_reset   (cpu_reset),
        .busy        (busy),
        .done        (done),
        .overflow    (overflow),
`ifdef IMEM_LOADER_CHECKSUM_EN
        .checksum    (checksum),
`endif
        .word_count  (word_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (instwen === 1'b1) begin
            addr_q.push_back(addwrite);
            data_q.push_back(instrdatain);
            cyc_q.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        addr_q.delete();
        data_q.delete();
        cyc_q.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Offers n words from src[]; a word not taken within 4 cycles ends the stream.
    task automatic send_words(input int n, input int last_idx, input bit gaps, output int acc);
        bit got;
        acc = 0;
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1;
            s_data  = src[i];
            s_last  = (i == last_idx);
            got = 1'b0;
            for (int k = 0; k < 4 && !got; k++) begin
                got = s_ready;
                tick();
            end
            if (!got) break;
            acc++;
            if (gaps && i < n - 1) begin
                s_valid = 1'b0;
                tick();
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_done(input string name, output int fall_cyc);
        int t = 0;
        fall_cyc = -1;
        while (t < 40) begin
            @(negedge clk);
            if (cpu_reset === 1'b0) begin
                fall_cyc = cyc;
                break;
            end
            t++;
        end
        n_chk++;
        if (fall_cyc < 0) $display("FAIL %s_release: cpu_reset never fell within 40 cycles", name);
        else n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
        tick(); tick();
        n_chk++;
        if ({s_ready, instwen, cpu_reset, busy, done, overflow} !== 6'b001000)
            $display("FAIL reset_ctrl: got %b expected 001000", {s_ready, instwen, cpu_reset, busy, done, overflow});
        else n_pass++;
        n_chk++;
        if (addwrite !== 32'h0 || instrdatain !== 32'h0 || word_count !== 16'd0)
            $display("FAIL reset_data: addr %h data %h cnt %0d expected 0/0/0", addwrite, instrdatain, word_count);
        else n_pass++;
        reset = 1'b0;
        tick();
        n_chk++;
        if (cpu_reset !== 1'b1 || s_ready !== 1'b0)
            $display("FAIL idle: cpu_reset %b s_ready %b expected 1/0", cpu_reset, s_ready);
        else n_pass++;
    endtask

    task automatic test_basic_load();
        int acc, fall;
        src[0] = 32'h20080005; src[1] = 32'h20090003; src[2] = 32'h01095020;
        clear_log();
        pulse_start();
        n_chk++;
        if (s_ready !== 1'b1 || busy !== 1'b1) $display("FAIL load_entry: s_ready %b busy %b expected 1/1", s_ready, busy);
        else n_pass++;
        send_words(3, 2, 1'b0, acc);
        n_chk++;
        if (s_ready !== 1'b0) $display("FAIL basic_ready_drop: s_ready %b expected 0", s_ready);
        else n_pass++;
        wait_done("basic", fall);
        n_chk++;
        if (addr_q.size() != 3) $display("FAIL basic_nwrites: got %0d expected 3", addr_q.size());
        else if (addr_q[0] !== 32'h0 || addr_q[1] !== 32'h4 || addr_q[2] !== 32'h8)
            $display("FAIL basic_addr: got %h %h %h expected 0 4 8", addr_q[0], addr_q[1], addr_q[2]);
        else if (data_q[0] !== 32'h20080005 || data_q[1] !== 32'h20090003 || data_q[2] !== 32'h01095020)
            $display("FAIL basic_data: got %h %h %h", data_q[0], data_q[1], data_q[2]);
        else if (cyc_q[1] != cyc_q[0] + 1 || cyc_q[2] != cyc_q[1] + 1)
            $display("FAIL basic_consec: write cycles %0d %0d %0d not consecutive", cyc_q[0], cyc_q[1], cyc_q[2]);
        else n_pass++;
        n_chk++;
        if (cyc_q.size() != 3 || fall != cyc_q[2] + 4)
            $display("FAIL basic_hold: cpu_reset fell at %0d expected last write + 4", fall);
        else n_pass++;
        n_chk++;
        if (done !== 1'b1 || busy !== 1'b0 || word_count !== 16'd3 || overflow !== 1'b0)
            $display("FAIL basic_run: done %b busy %b cnt %0d ovf %b expected 1/0/3/0", done, busy, word_count, overflow);
        else n_pass++;
    endtask

    task automatic test_gapped_load();
        int acc, fall;
        clear_log();
        pulse_start();
        send_words(3, 2, 1'b1, acc);
        wait_done("gapped", fall);
        n_chk++;
        if (addr_q.size() != 3) $display("FAIL gap_nwrites: got %0d expected 3", addr_q.size());
        else if (addr_q[0] !== 32'h0 || addr_q[1] !== 32'h4 || addr_q[2] !== 32'h8 ||
                 data_q[0] !== 32'h20080005 || data_q[1] !== 32'h20090003 || data_q[2] !== 32'h01095020)
            $display("FAIL gap_seq: addr %h %h %h data %h %h %h", addr_q[0], addr_q[1], addr_q[2], data_q[0], data_q[1], data_q[2]);
        else if (cyc_q[1] != cyc_q[0] + 2 || cyc_q[2] != cyc_q[1] + 2)
            $display("FAIL gap_timing: write cycles %0d %0d %0d expected spacing 2", cyc_q[0], cyc_q[1], cyc_q[2]);
        else n_pass++;
        n_chk++;
        if (word_count !== 16'd3) $display("FAIL gap_count: got %0d expected 3", word_count);
        else n_pass++;
    endtask

    task automatic test_overflow();
        int acc, acc2, fall;
        for (int i = 0; i < 6; i++) src[i] = 32'hA000_0000 + 32'(i);
        clear_log();
        pulse_start();
        send_words(4, -1, 1'b0, acc);
        n_chk++;
        if (acc != 4 || s_ready !== 1'b0 || overflow !== 1'b1)
            $display("FAIL ovf_stop: acc %0d s_ready %b ovf %b expected 4/0/1", acc, s_ready, overflow);
        else n_pass++;
        src[0] = src[4]; src[1] = src[5];
        send_words(2, -1, 1'b0, acc2);
        n_chk++;
        if (acc2 != 0) $display("FAIL ovf_extra: %0d extra words accepted expected 0", acc2);
        else n_pass++;
        wait_done("ovf", fall);
        n_chk++;
        if (addr_q.size() != 4) $display("FAIL ovf_nwrites: got %0d expected 4", addr_q.size());
        else if (addr_q[0] !== 32'h0 || addr_q[1] !== 32'h4 || addr_q[2] !== 32'h8 || addr_q[3] !== 32'hC ||
                 data_q[3] !== 32'hA000_0003)
            $display("FAIL ovf_seq: addr %h %h %h %h last data %h", addr_q[0], addr_q[1], addr_q[2], addr_q[3], data_q[3]);
        else n_pass++;
        n_chk++;
        if (overflow !== 1'b1 || word_count !== 16'd4 || done !== 1'b1)
            $display("FAIL ovf_run: ovf %b cnt %0d done %b expected 1/4/1", overflow, word_count, done);
        else n_pass++;
    endtask

    task automatic test_restart_from_run();
        int acc, fall;
        src[0] = 32'hDEADBEEF;
        clear_log();
        pulse_start();
        n_chk++;
        if (cpu_reset !== 1'b1 || done !== 1'b0 || overflow !== 1'b0 || word_count !== 16'd0)
            $display("FAIL restart_entry: cpu_reset %b done %b ovf %b cnt %0d expected 1/0/0/0",
                     cpu_reset, done, overflow, word_count);
        else n_pass++;
        send_words(1, 0, 1'b0, acc);
        wait_done("restart", fall);
        n_chk++;
        if (addr_q.size() != 1 || addr_q[0] !== 32'h0 || data_q[0] !== 32'hDEADBEEF)
            $display("FAIL restart_write: n %0d expected single write of deadbeef at 0", addr_q.size());
        else n_pass++;
        n_chk++;
        if (word_count !== 16'd1 || overflow !== 1'b0)
            $display("FAIL restart_count: cnt %0d ovf %b expected 1/0", word_count, overflow);
        else n_pass++;
    endtask

    task automatic test_reset_mid_load();
        int acc, fall;
        for (int i = 0; i < 5; i++) src[i] = 32'h1100_0000 + 32'(i);
        clear_log();
        pulse_start();
        send_words(2, -1, 1'b0, acc);
        s_valid = 1'b1; s_data = src[2]; reset = 1'b1;
        tick();
        n_chk++;
        if (instwen !== 1'b0 || cpu_reset !== 1'b1 || word_count !== 16'd0 || busy !== 1'b0 || s_ready !== 1'b0)
            $display("FAIL midreset_state: wen %b cpu_reset %b cnt %0d busy %b rdy %b expected 0/1/0/0/0",
                     instwen, cpu_reset, word_count, busy, s_ready);
        else n_pass++;
        s_valid = 1'b0; reset = 1'b0;
        tick(); tick();
        n_chk++;
        if (addr_q.size() != 2) $display("FAIL midreset_writes: got %0d expected 2", addr_q.size());
        else n_pass++;
        clear_log();
        src[0] = 32'h2222_0000; src[1] = 32'h2222_0001;
        pulse_start();
        send_words(2, 1, 1'b0, acc);
        wait_done("reload", fall);
        n_chk++;
        if (addr_q.size() != 2 || addr_q[0] !== 32'h0 || addr_q[1] !== 32'h4 ||
            data_q[0] !== 32'h2222_0000 || data_q[1] !== 32'h2222_0001)
            $display("FAIL reload_seq: n %0d expected writes at 0 and 4", addr_q.size());
        else n_pass++;
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        int acc, fall;
        src[0] = 32'hFFFF_FFFF; src[1] = 32'h0000_0002;
        pulse_start();
        n_chk++;
        if (checksum !== 32'h0) $display("FAIL csum_clear: got %h expected 00000000", checksum);
        else n_pass++;
        send_words(2, 1, 1'b0, acc);
        n_chk++;
        if (checksum !== 32'h1) $display("FAIL csum_write: got %h expected 00000001", checksum);
        else n_pass++;
        wait_done("csum", fall);
        n_chk++;
        if (checksum !== 32'h1) $display("FAIL csum_run: got %h expected 00000001", checksum);
        else n_pass++;
    endtask
`endif

    initial begin
        reset = 1'b1; start = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
        test_reset();
        test_basic_load();
        test_gapped_load();
        test_overflow();
        test_restart_from_run();
        test_reset_mid_load();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
